// File: rtl/tx_hs_sequencer.sv
// HS transmit byte sequencer: frames a payload burst as leader, sync, payload
// and trailer bytes on a registered byte bus for the serializer.
module tx_hs_sequencer #(
    parameter int unsigned LEADER_BYTES  = 1,
    parameter int unsigned TRAILER_BYTES = 2
) (
    input  logic       TxByteClkHS,
    input  logic       Rst,
    input  logic       Enable,
    input  logic       TxRequestHS,
    input  logic [7:0] TxDataHS,
    output logic       TxReadyHS,
    output logic [7:0] DataHS,
    output logic       HsActive
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEADER  = 3'd1,
        ST_SYNC    = 3'd2,
        ST_DATA    = 3'd3,
        ST_TRAILER = 3'd4,
        ST_EXIT    = 3'd5
    } state_e;

    localparam logic [7:0] SYNC_BYTE    = 8'hB8;
    localparam logic [3:0] LEADER_LOAD  = 4'(LEADER_BYTES - 1);
    localparam logic [3:0] TRAILER_LOAD = 4'(TRAILER_BYTES - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] data_q, data_d;
    logic       active_q, active_d;
    logic       last_bit_q, last_bit_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        active_d   = active_q;
        last_bit_d = last_bit_q;

        if (!Enable) begin
            state_d    = ST_IDLE;
            cnt_d      = 4'd0;
            data_d     = 8'h00;
            active_d   = 1'b0;
            last_bit_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    data_d   = 8'h00;
                    active_d = 1'b0;
                    if (TxRequestHS) begin
                        state_d  = ST_LEADER;
                        active_d = 1'b1;
                        cnt_d    = LEADER_LOAD;
                    end
                end
                ST_LEADER: begin
                    data_d   = 8'h00;
                    active_d = 1'b1;
                    if (cnt_q == 4'd0) begin
                        state_d    = ST_SYNC;
                        data_d     = SYNC_BYTE;
                        // A burst with no payload ends on the sync byte, whose MSB is 1.
                        last_bit_d = SYNC_BYTE[7];
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                ST_SYNC, ST_DATA: begin
                    active_d = 1'b1;
                    if (TxRequestHS) begin
                        state_d    = ST_DATA;
                        data_d     = TxDataHS;
                        last_bit_d = TxDataHS[7];
                    end else begin
                        state_d = ST_TRAILER;
                        data_d  = {8{~last_bit_q}};
                        cnt_d   = TRAILER_LOAD;
                    end
                end
                ST_TRAILER: begin
                    active_d = 1'b1;
                    if (cnt_q == 4'd0) begin
                        state_d  = ST_EXIT;
                        data_d   = 8'h00;
                        active_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                ST_EXIT: begin
                    state_d  = ST_IDLE;
                    data_d   = 8'h00;
                    active_d = 1'b0;
                end
                default: begin
                    state_d    = ST_IDLE;
                    cnt_d      = 4'd0;
                    data_d     = 8'h00;
                    active_d   = 1'b0;
                    last_bit_d = 1'b0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge TxByteClkHS or posedge Rst) begin
        if (Rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            data_q     <= 8'h00;
            active_q   <= 1'b0;
            last_bit_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            active_q   <= active_d;
            last_bit_q <= last_bit_d;
        end
    end

    assign TxReadyHS = (state_q == ST_SYNC) || (state_q == ST_DATA);
    assign DataHS    = data_q;
    assign HsActive  = active_q;

endmodule

// File: tb/tb_tx_hs_sequencer.sv
// Self-checking bench for tx_hs_sequencer: default instance A and a
// LEADER_BYTES=3 / TRAILER_BYTES=1 instance B share clock and reset.
module tb_tx_hs_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_en, a_req, a_rdy, a_act;
    logic [7:0] a_din, a_data;
    logic       b_en, b_req, b_rdy, b_act;
    logic [7:0] b_din, b_data;

    always #5 clk = ~clk;

    tx_hs_sequencer u_dut_a (
        .TxByteClkHS (clk),
        .Rst         (rst),
        .Enable      (a_en),
        .TxRequestHS (a_req),
        .TxDataHS    (a_din),
        .TxReadyHS   (a_rdy),
        .DataHS      (a_data),
        .HsActive    (a_act)
    );

    tx_hs_sequencer #(
        .LEADER_BYTES  (3),
        .TRAILER_BYTES (1)
    ) u_dut_b (
        .TxByteClkHS (clk),
        .Rst         (rst),
        .Enable      (b_en),
        .TxRequestHS (b_req),
        .TxDataHS    (b_din),
        .TxReadyHS   (b_rdy),
        .DataHS      (b_data),
        .HsActive    (b_act)
    );

    // One cycle of stimulus and the outputs expected just after the following edge.
    typedef struct {
        bit         inst;
        logic       en;
        logic       req;
        logic [7:0] din;
        logic [7:0] exp_data;
        logic       exp_act;
        logic       exp_rdy;
        int         id;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    vec_t cur;
    int   checks  = 0;
    int   errors  = 0;
    int   next_id = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit inst, input logic en, input logic req,
                                input logic [7:0] din, input logic [7:0] exp_data,
                                input logic exp_act, input logic exp_rdy);
        vec_t v;
        v.inst     = inst;
        v.en       = en;
        v.req      = req;
        v.din      = din;
        v.exp_data = exp_data;
        v.exp_act  = exp_act;
        v.exp_rdy  = exp_rdy;
        v.id       = next_id;
        next_id++;
        return v;
    endfunction

    function automatic void add(input bit inst, input logic en, input logic req,
                                input logic [7:0] din, input logic [7:0] exp_data,
                                input logic exp_act, input logic exp_rdy);
        vecs.push_back(mk(inst, en, req, din, exp_data, exp_act, exp_rdy));
    endfunction

    // Drive on the falling edge; the idle instance is held enabled with no request.
    task automatic drive(input vec_t v);
        @(negedge clk);
        a_en = 1'b1; a_req = 1'b0; a_din = 8'h00;
        b_en = 1'b1; b_req = 1'b0; b_din = 8'h00;
        if (v.inst == 1'b0) begin
            a_en = v.en; a_req = v.req; a_din = v.din;
        end else begin
            b_en = v.en; b_req = v.req; b_din = v.din;
        end
        sb.push_back(v);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            cur = sb.pop_front();
            if (cur.inst == 1'b0) begin
                check($sformatf("v%0d_A_DataHS", cur.id), a_data, cur.exp_data);
                check($sformatf("v%0d_A_HsActive", cur.id), {7'd0, a_act}, {7'd0, cur.exp_act});
                check($sformatf("v%0d_A_TxReadyHS", cur.id), {7'd0, a_rdy}, {7'd0, cur.exp_rdy});
            end else begin
                check($sformatf("v%0d_B_DataHS", cur.id), b_data, cur.exp_data);
                check($sformatf("v%0d_B_HsActive", cur.id), {7'd0, b_act}, {7'd0, cur.exp_act});
                check($sformatf("v%0d_B_TxReadyHS", cur.id), {7'd0, b_rdy}, {7'd0, cur.exp_rdy});
            end
        end
    end

    initial begin
        rst = 1'b0;
        a_en = 1'b0; a_req = 1'b0; a_din = 8'h00;
        b_en = 1'b0; b_req = 1'b0; b_din = 8'h00;
        #1 rst = 1'b1;
        #1;
        // Reset must act before any clock edge has occurred.
        check("reset_A_DataHS", a_data, 8'h00);
        check("reset_A_HsActive", {7'd0, a_act}, 8'h00);
        check("reset_A_TxReadyHS", {7'd0, a_rdy}, 8'h00);
        check("reset_B_DataHS", b_data, 8'h00);
        check("reset_B_HsActive", {7'd0, b_act}, 8'h00);
        check("reset_B_TxReadyHS", {7'd0, b_rdy}, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic burst: 00, B8, 01, FE, trailer 00 00, then EXIT.
        add(0, 1, 1, 8'h00, 8'h00, 1, 0);
        add(0, 1, 1, 8'h00, 8'hB8, 1, 1);
        add(0, 1, 1, 8'h01, 8'h01, 1, 1);
        add(0, 1, 1, 8'hFE, 8'hFE, 1, 1);
        add(0, 1, 0, 8'h00, 8'h00, 1, 0);
        add(0, 1, 0, 8'h00, 8'h00, 1, 0);
        add(0, 1, 0, 8'h00, 8'h00, 0, 0);
        add(0, 1, 0, 8'h00, 8'h00, 0, 0);
        // Last byte 7F gives an FF trailer; request reasserted during EXIT.
        add(0, 1, 1, 8'h00, 8'h00, 1, 0);
        add(0, 1, 1, 8'h00, 8'hB8, 1, 1);
        add(0, 1, 1, 8'h7F, 8'h7F, 1, 1);
        add(0, 1, 0, 8'h00, 8'hFF, 1, 0);
        add(0, 1, 0, 8'h00, 8'hFF, 1, 0);
        add(0, 1, 0, 8'h00, 8'h00, 0, 0);
        add(0, 1, 1, 8'h00, 8'h00, 0, 0);
        add(0, 1, 1, 8'h00, 8'h00, 1, 0);
        // Zero-payload burst: request dropped during SYNC.
        add(0, 1, 1, 8'h00, 8'hB8, 1, 1);
        add(0, 1, 0, 8'h00, 8'h00, 1, 0);
        add(0, 1, 0, 8'h00, 8'h00, 1, 0);
        add(0, 1, 0, 8'h00, 8'h00, 0, 0);
        add(0, 1, 0, 8'h00, 8'h00, 0, 0);
        // Enable dropped in the second payload cycle: no trailer.
        add(0, 1, 1, 8'h00, 8'h00, 1, 0);
        add(0, 1, 1, 8'h00, 8'hB8, 1, 1);
        add(0, 1, 1, 8'h11, 8'h11, 1, 1);
        add(0, 1, 1, 8'h22, 8'h22, 1, 1);
        add(0, 0, 1, 8'h33, 8'h00, 0, 0);
        add(0, 1, 0, 8'h00, 8'h00, 0, 0);
        add(0, 1, 0, 8'h00, 8'h00, 0, 0);
        add(0, 0, 1, 8'h00, 8'h00, 0, 0);
        add(0, 1, 0, 8'h00, 8'h00, 0, 0);
        // Instance B: three leader bytes, one trailer byte.
        add(1, 1, 1, 8'h00, 8'h00, 1, 0);
        add(1, 1, 1, 8'h00, 8'h00, 1, 0);
        add(1, 1, 1, 8'h00, 8'h00, 1, 0);
        add(1, 1, 1, 8'h00, 8'hB8, 1, 1);
        add(1, 1, 1, 8'h3C, 8'h3C, 1, 1);
        add(1, 1, 0, 8'h00, 8'hFF, 1, 0);
        add(1, 1, 0, 8'h00, 8'h00, 0, 0);
        add(1, 1, 0, 8'h00, 8'h00, 0, 0);
        // Instance B: drop during LEADER still emits sync then a 00 trailer.
        add(1, 1, 1, 8'h00, 8'h00, 1, 0);
        add(1, 1, 0, 8'h00, 8'h00, 1, 0);
        add(1, 1, 0, 8'h00, 8'h00, 1, 0);
        add(1, 1, 0, 8'h00, 8'hB8, 1, 1);
        add(1, 1, 0, 8'h00, 8'h00, 1, 0);
        add(1, 1, 0, 8'h00, 8'h00, 0, 0);
        add(1, 1, 0, 8'h00, 8'h00, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
        end

        // Reset pulsed mid-DATA clears outputs without waiting for a clock edge.
        drive(mk(0, 1, 1, 8'h00, 8'h00, 1, 0));
        drive(mk(0, 1, 1, 8'h00, 8'hB8, 1, 1));
        drive(mk(0, 1, 1, 8'h5A, 8'h5A, 1, 1));
        @(posedge clk);
        #2;
        a_req = 1'b0;
        rst   = 1'b1;
        #1;
        check("rst_mid_A_DataHS", a_data, 8'h00);
        check("rst_mid_A_HsActive", {7'd0, a_act}, 8'h00);
        check("rst_mid_A_TxReadyHS", {7'd0, a_rdy}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        drive(mk(0, 1, 1, 8'h00, 8'h00, 1, 0));
        drive(mk(0, 1, 1, 8'h00, 8'hB8, 1, 1));
        drive(mk(0, 1, 0, 8'h00, 8'h00, 1, 0));
        drive(mk(0, 1, 0, 8'h00, 8'h00, 1, 0));
        drive(mk(0, 1, 0, 8'h00, 8'h00, 0, 0));
        drive(mk(0, 1, 0, 8'h00, 8'h00, 0, 0));

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 8'(sb.size()), 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_hs_sequencer.md
TX_HS_SEQUENCER -- requirements
Module: tx_hs_sequencer

Interface
REQ-001 The block SHALL have parameter LEADER_BYTES, default 1, meaning the number of 8'h00 leader bytes sent before the sync byte, with legal range 1..15.
REQ-002 The block SHALL have parameter TRAILER_BYTES, default 2, meaning the number of trailer bytes sent after the last payload byte, with legal range 1..15.
REQ-003 The block SHALL have port TxByteClkHS, input, 1 bit: the HS byte clock, with all state changing on its rising edge.
REQ-004 The block SHALL have port Rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port Enable, input, 1 bit: block enable; low forces IDLE.
REQ-006 The block SHALL have port TxRequestHS, input, 1 bit: HS burst request from the protocol layer.
REQ-007 The block SHALL have port TxDataHS, input, 8 bits: payload byte, bit 0 transmitted first.
REQ-008 The block SHALL have port TxReadyHS, output, 1 bit: payload byte accept strobe.
REQ-009 The block SHALL have port DataHS, output, 8 bits: registered serializer byte, bit 0 first on the line.
REQ-010 The block SHALL have port HsActive, output, 1 bit: registered flag, high while leader, sync, payload or trailer bytes are on DataHS.

Function
REQ-011 The block SHALL implement states IDLE, LEADER, SYNC, DATA, TRAILER and EXIT in a single registered FSM, with a 4-bit down-counter for LEADER and TRAILER.
REQ-012 TxReadyHS SHALL be decoded from registered state only, high exactly when state is SYNC or DATA.
REQ-013 In IDLE, with Enable=1 and TxRequestHS=1 sampled, the next state SHALL be LEADER, with DataHS=8'h00, HsActive=1 and counter=LEADER_BYTES-1.
REQ-014 LEADER SHALL hold DataHS=8'h00 for exactly LEADER_BYTES cycles, then go to SYNC.
REQ-015 On entry to SYNC, DataHS SHALL be 8'hB8 (line order 0001_1101) for exactly one cycle.
REQ-016 A payload byte SHALL be accepted on every edge where TxReadyHS=1 and TxRequestHS=1: DataHS<=TxDataHS, LastBit<=TxDataHS[7], and next state is DATA; latency is one cycle.
REQ-017 On an edge where TxReadyHS=1 and TxRequestHS=0, the next state SHALL be TRAILER, DataHS<={8{~LastBit}} and counter=TRAILER_BYTES-1.
REQ-018 If the request drops while in SYNC (zero-payload burst), LastBit SHALL be taken as 1 (the MSB of 8'hB8), giving a trailer of 8'h00.
REQ-019 TRAILER SHALL hold its byte for exactly TRAILER_BYTES cycles, then go to EXIT.
REQ-020 In EXIT, for one cycle, the block SHALL drive HsActive=0 and DataHS=8'h00, then go to IDLE; a new request SHALL NOT be sampled in EXIT.
REQ-021 TxRequestHS SHALL be ignored in LEADER, TRAILER and EXIT; a drop during LEADER still emits sync, then the trailer.
REQ-022 Enable=0 sampled in any state SHALL force, on the next edge, state IDLE, DataHS=8'h00, HsActive=0 and LastBit=0, aborting the burst without a trailer.
REQ-023 DataHS SHALL change only on rising edges of TxByteClkHS and SHALL never glitch between bytes.

Reset
REQ-024 While Rst=1, the block SHALL immediately force state=IDLE, DataHS=8'h00, HsActive=0, TxReadyHS=0, counter=0 and LastBit=0, independent of the clock.
REQ-025 Rst asserted mid-burst SHALL abort with no trailer; after release, the first request SHALL start a fresh leader.

Verification
REQ-026 The bench SHALL cover a basic burst with defaults: request with payload 8'h01 then 8'hFE, then drop the request -> DataHS = 00, B8, 01, FE, 00, 00, then 00 with HsActive low, and TxReadyHS high for exactly 3 cycles.
REQ-027 The bench SHALL cover a trailer polarity check: last byte 8'h7F -> trailer bytes 8'hFF, 8'hFF.
REQ-028 The bench SHALL cover a zero payload: request held 2 cycles, dropped during SYNC -> DataHS = 00, B8, 00, 00, then EXIT.
REQ-029 The bench SHALL cover parameters: LEADER_BYTES=3, TRAILER_BYTES=1 -> three 8'h00 leader bytes, then B8, and exactly one trailer byte.
REQ-030 The bench SHALL cover an abort: Enable dropped in the 2nd payload cycle -> next edge HsActive=0, DataHS=00, no trailer; likewise, Rst pulsed mid-DATA clears outputs immediately.
REQ-031 The bench SHALL cover back-to-back bursts: request reasserted during EXIT -> not sampled until IDLE, so the next LEADER starts exactly 2 edges after the EXIT cycle begins.
